// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60Hz timing constants and position helpers for the VGA sync generator
// and the pattern/memory blocks that use the same blank limits.
package vga_sync_gen_pkg;

    localparam int POS_W    = 10;

    localparam int H_VIS    = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS    = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    // True when a counter value lies inside an inclusive [lo, hi] window.
    function automatic logic inWindow(input logic [POS_W-1:0] pos, input int lo, input int hi);
        return (int'(pos) >= lo) && (int'(pos) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_clk_tick_div.sv
// Reusable rate strobe: tick is high during the last Clk cycle of every DIV-cycle period.
module clk_tick_div #(
    parameter int DIV = 2
) (
    input  logic Clk,
    input  logic reset,
    output logic tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div;

    // With DIV=1 the counter sits at zero and tick stays high continuously.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    assign tick = (div == DW'(DIV - 1));

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel position, hsync/vsync and video_on for a 640x480@60Hz raster.
// Optional one-cycle frame_start strobe when VGA_FRAME_STROBE_EN is defined.
module vga_sync_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = vga_sync_gen_pkg::H_VIS,
    parameter int H_FP    = vga_sync_gen_pkg::H_FP,
    parameter int H_SYNC  = vga_sync_gen_pkg::H_SYNC,
    parameter int H_BP    = vga_sync_gen_pkg::H_BP,
    parameter int V_VIS   = vga_sync_gen_pkg::V_VIS,
    parameter int V_FP    = vga_sync_gen_pkg::V_FP,
    parameter int V_SYNC  = vga_sync_gen_pkg::V_SYNC,
    parameter int V_BP    = vga_sync_gen_pkg::V_BP
) (
    input  logic       Clk,
    input  logic       reset,
    output logic [9:0] Posx,
    output logic [9:0] Posy,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick
`ifdef VGA_FRAME_STROBE_EN
    ,
    output logic       frame_start
`endif
);

    import vga_sync_gen_pkg::*;

    localparam int HT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_LO = H_VIS + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC - 1;
    localparam int VS_LO = V_VIS + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC - 1;

    generate
        if (HT > 1024 || VT > 1024 || CLK_DIV < 1) begin : g_bad_cfg
            $error("vga_sync_gen: totals must fit 10-bit counters and CLK_DIV must be >= 1");
        end
    endgenerate

    logic       tick;
    logic       xWrap;
    logic       frameWrap;
    logic [9:0] nextX;
    logic [9:0] nextY;

    clk_tick_div #(.DIV(CLK_DIV)) u_div (
        .Clk  (Clk),
        .reset(reset),
        .tick (tick)
    );

    // Next raster position; the sync registers use it so they change on the same edge.
    always_comb begin
        xWrap     = (Posx == 10'(HT - 1));
        frameWrap = xWrap && (Posy == 10'(VT - 1));
        nextX     = xWrap ? 10'd0 : Posx + 10'd1;
        nextY     = Posy;
        if (xWrap) begin
            nextY = (Posy == 10'(VT - 1)) ? 10'd0 : Posy + 10'd1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            Posx        <= '0;
            Posy        <= '0;
            pix_tick    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
`ifdef VGA_FRAME_STROBE_EN
            frame_start <= 1'b0;
`endif
        end else begin
            pix_tick    <= tick;
`ifdef VGA_FRAME_STROBE_EN
            frame_start <= tick && frameWrap;
`endif
            if (tick) begin
                Posx  <= nextX;
                Posy  <= nextY;
                hsync <= !inWindow(nextX, HS_LO, HS_HI);
                vsync <= !inWindow(nextY, VS_LO, VS_HI);
            end
        end
    end

    assign video_on = (Posx < 10'(H_VIS)) && (Posy < 10'(V_VIS));

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full-size timing for line/reset behaviour, a reduced raster
// for whole-frame behaviour, and a CLK_DIV=1 instance for the undivided case.
module tb_vga_sync_gen;

    localparam int S_HV = 8, S_HFP = 2, S_HS = 3, S_HBP = 2;
    localparam int S_VV = 4, S_VFP = 1, S_VS = 2, S_VBP = 1;
    localparam int S_HT = 15, S_VT = 8;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    int         cyc;
    int         checks = 0;
    int         failures = 0;

    logic [9:0] posxA, posyA, posxS, posyS, posxO, posyO;
    logic       hsyncA, vsyncA, video_onA, pix_tickA;
    logic       hsyncS, vsyncS, video_onS, pix_tickS;
    logic       hsyncO, vsyncO, video_onO, pix_tickO;
`ifdef VGA_FRAME_STROBE_EN
    logic       frameStartA, frameStartS, frameStartO;
`endif

    always #5 Clk = ~Clk;

    // Posedges since the last reset release; the model derives every expectation from it.
    always @(posedge Clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    vga_sync_gen dutA (
        .Clk(Clk), .reset(reset), .Posx(posxA), .Posy(posyA), .hsync(hsyncA),
        .vsync(vsyncA), .video_on(video_onA), .pix_tick(pix_tickA)
`ifdef VGA_FRAME_STROBE_EN
        , .frame_start(frameStartA)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) dutS (
        .Clk(Clk), .reset(reset), .Posx(posxS), .Posy(posyS), .hsync(hsyncS),
        .vsync(vsyncS), .video_on(video_onS), .pix_tick(pix_tickS)
`ifdef VGA_FRAME_STROBE_EN
        , .frame_start(frameStartS)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_VIS(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_VIS(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
    ) dutO (
        .Clk(Clk), .reset(reset), .Posx(posxO), .Posy(posyO), .hsync(hsyncO),
        .vsync(vsyncO), .video_on(video_onO), .pix_tick(pix_tickO)
`ifdef VGA_FRAME_STROBE_EN
        , .frame_start(frameStartO)
`endif
    );

    function automatic int expX(input int n, input int d, input int ht);
        return (n / d) % ht;
    endfunction

    function automatic int expY(input int n, input int d, input int ht, input int vt);
        return ((n / d) / ht) % vt;
    endfunction

    function automatic logic inRange(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge Clk);
        checks++; if (posxA !== 10'd0) begin failures++; $display("[TB] FAIL reset_posx got=%0d want=0", posxA); end
        checks++; if (posyA !== 10'd0) begin failures++; $display("[TB] FAIL reset_posy got=%0d want=0", posyA); end
        checks++; if ({hsyncA, vsyncA} !== 2'b11) begin failures++; $display("[TB] FAIL reset_syncs got=%b want=11", {hsyncA, vsyncA}); end
        checks++; if ({pix_tickA, video_onA} !== 2'b01) begin failures++; $display("[TB] FAIL reset_tick_von got=%b want=01", {pix_tickA, video_onA}); end
        reset = 1'b0;
        @(negedge Clk);
        checks++; if ({pix_tickA, posxA} !== {1'b0, 10'd0}) begin failures++; $display("[TB] FAIL first_edge_div2 tick=%b posx=%0d want tick=0 posx=0", pix_tickA, posxA); end
        checks++; if ({pix_tickO, posxO} !== {1'b1, 10'd1}) begin failures++; $display("[TB] FAIL first_edge_div1 tick=%b posx=%0d want tick=1 posx=1", pix_tickO, posxO); end
        @(negedge Clk);
        checks++; if ({pix_tickA, posxA} !== {1'b1, 10'd1}) begin failures++; $display("[TB] FAIL first_tick_div2 tick=%b posx=%0d want tick=1 posx=1", pix_tickA, posxA); end
`ifdef VGA_FRAME_STROBE_EN
        checks++; if ({frameStartA, frameStartS, frameStartO} !== 3'b000) begin failures++; $display("[TB] FAIL no_strobe_after_reset got=%b want=000", {frameStartA, frameStartS, frameStartO}); end
`endif
    endtask

    task automatic test_line();
        int bad = 0, firstBad = -1, hsLow = 0, firstLowX = -1;
        logic vo639 = 1'b0, vo640 = 1'b1, sawY1 = 1'b0;
        int ex, ey;
        while (cyc < 1604) begin
            @(negedge Clk);
            ex = expX(cyc, 2, 800);
            ey = expY(cyc, 2, 800, 525);
            if (posxA !== 10'(ex) || posyA !== 10'(ey) || hsyncA !== !inRange(ex, 656, 751) ||
                vsyncA !== 1'b1 || video_onA !== (ex < 640 && ey < 480) || pix_tickA !== (cyc % 2 == 0)) begin
                bad++;
                if (firstBad < 0) firstBad = cyc;
            end
            if (pix_tickA && !hsyncA) begin
                hsLow++;
                if (firstLowX < 0) firstLowX = int'(posxA);
            end
            if (posxA == 10'd639 && posyA == 10'd0) vo639 = video_onA;
            if (posxA == 10'd640 && posyA == 10'd0) vo640 = video_onA;
            if (posxA == 10'd0 && posyA == 10'd1) sawY1 = 1'b1;
        end
        checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL line_model bad_cycles=%0d first_cycle=%0d want 0", bad, firstBad); end
        checks++; if (hsLow !== 96) begin failures++; $display("[TB] FAIL hsync_width got=%0d want=96", hsLow); end
        checks++; if (firstLowX !== 656) begin failures++; $display("[TB] FAIL hsync_start got=%0d want=656", firstLowX); end
        checks++; if (vo639 !== 1'b1) begin failures++; $display("[TB] FAIL video_on_639_0 got=%b want=1", vo639); end
        checks++; if (vo640 !== 1'b0) begin failures++; $display("[TB] FAIL video_on_640_0 got=%b want=0", vo640); end
        checks++; if (sawY1 !== 1'b1) begin failures++; $display("[TB] FAIL posy_increment got=%b want=1", sawY1); end
    endtask

    task automatic test_async_reset();
        int waited = 0;
        while (posxA != 10'd300 && waited < 2000) begin
            @(negedge Clk);
            waited++;
        end
        checks++; if (posxA !== 10'd300) begin failures++; $display("[TB] FAIL reach_posx_300 got=%0d want=300", posxA); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({posxA, posyA} !== 20'd0) begin failures++; $display("[TB] FAIL async_pos got=%0d,%0d want=0,0", posxA, posyA); end
        checks++; if ({hsyncA, vsyncA, video_onA, pix_tickA} !== 4'b1110) begin failures++; $display("[TB] FAIL async_flags got=%b want=1110", {hsyncA, vsyncA, video_onA, pix_tickA}); end
        checks++; if ({posxS, posyS, posxO, posyO} !== 40'd0) begin failures++; $display("[TB] FAIL async_small got=%0d,%0d,%0d,%0d want zeros", posxS, posyS, posxO, posyO); end
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if ({posxA, posyA} !== {10'd1, 10'd0}) begin failures++; $display("[TB] FAIL restart_pos got=%0d,%0d want=1,0", posxA, posyA); end
    endtask

    task automatic test_frame();
        int badS = 0, badO = 0, firstBad = -1, vsLow = 0, voCnt = 0;
        int fsS = 0, fsO = 0, fsBadPos = 0;
        logic voCorner = 1'b0, voRight = 1'b1, voBelow = 1'b1, wrapOk = 1'b0;
        int ex, ey, eo, fo;
        reset = 1'b1;
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        repeat (482) begin
            @(negedge Clk);
            ex = expX(cyc, 2, S_HT);
            ey = expY(cyc, 2, S_HT, S_VT);
            eo = expX(cyc, 1, S_HT);
            fo = expY(cyc, 1, S_HT, S_VT);
            if (posxS !== 10'(ex) || posyS !== 10'(ey) || hsyncS !== !inRange(ex, 10, 12) ||
                vsyncS !== !inRange(ey, 5, 6) || video_onS !== (ex < 8 && ey < 4) || pix_tickS !== (cyc % 2 == 0)) begin
                badS++;
                if (firstBad < 0) firstBad = cyc;
            end
            if (posxO !== 10'(eo) || posyO !== 10'(fo) || hsyncO !== !inRange(eo, 10, 12) ||
                vsyncO !== !inRange(fo, 5, 6) || video_onO !== (eo < 8 && fo < 4) || pix_tickO !== 1'b1) begin
                badO++;
            end
            if (cyc <= 240 && pix_tickS && !vsyncS) vsLow++;
            if (cyc <= 240 && pix_tickS && video_onS) voCnt++;
            if (cyc == 240 && posxS == 10'd0 && posyS == 10'd0) wrapOk = 1'b1;
            if (posxS == 10'd7 && posyS == 10'd3) voCorner = video_onS;
            if (posxS == 10'd8 && posyS == 10'd0) voRight = video_onS;
            if (posxS == 10'd0 && posyS == 10'd4) voBelow = video_onS;
`ifdef VGA_FRAME_STROBE_EN
            if (frameStartS) begin
                fsS++;
                if (posxS != 10'd0 || posyS != 10'd0 || !pix_tickS) fsBadPos++;
            end
            if (frameStartO) begin
                fsO++;
                if (posxO != 10'd0 || posyO != 10'd0) fsBadPos++;
            end
`endif
        end
        checks++; if (badS !== 0) begin failures++; $display("[TB] FAIL frame_model_div2 bad_cycles=%0d first_cycle=%0d want 0", badS, firstBad); end
        checks++; if (badO !== 0) begin failures++; $display("[TB] FAIL frame_model_div1 bad_cycles=%0d want 0", badO); end
        checks++; if (vsLow !== S_VS * S_HT) begin failures++; $display("[TB] FAIL vsync_ticks got=%0d want=%0d", vsLow, S_VS * S_HT); end
        checks++; if (voCnt !== S_HV * S_VV) begin failures++; $display("[TB] FAIL video_on_ticks got=%0d want=%0d", voCnt, S_HV * S_VV); end
        checks++; if (wrapOk !== 1'b1) begin failures++; $display("[TB] FAIL frame_wrap_origin got=%0d,%0d want=0,0 at tick 120", posxS, posyS); end
        checks++; if ({voCorner, voRight, voBelow} !== 3'b100) begin failures++; $display("[TB] FAIL video_on_edges got=%b want=100", {voCorner, voRight, voBelow}); end
`ifdef VGA_FRAME_STROBE_EN
        checks++; if (fsS !== 2) begin failures++; $display("[TB] FAIL frame_start_count_div2 got=%0d want=2", fsS); end
        checks++; if (fsO !== 4) begin failures++; $display("[TB] FAIL frame_start_count_div1 got=%0d want=4", fsO); end
        checks++; if (fsBadPos !== 0) begin failures++; $display("[TB] FAIL frame_start_alignment misaligned=%0d want=0", fsBadPos); end
`endif
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_async_reset();
        test_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
